mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl.sv | 174 +++++++++++++++++
 tb/tb_mem_req_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: bridges the pipeline memory stage to mem_system.
// Accepts one aligned load/store at a time, holds it on the mem_system
// interface until mem_done, stalls the pipeline meanwhile, and keeps
// request/hit statistics plus a sticky fatal error (mem_err or watchdog).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   req_valid/wr/addr/wdata/dump   pipeline request
//   stall, resp_valid, resp_rdata, align_err, err   pipeline status/response
//   mem_addr/datain/rd/wr/createdump   to mem_system
//   mem_dataout/done/cachehit/err      from mem_system
//   req_cnt, hit_cnt    saturating completion / cache-hit counters
module mem_req_ctrl #(
    parameter int unsigned WDOG_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_wr,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    input  logic        req_dump,
    output logic        stall,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        align_err,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_datain,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_createdump,
    input  logic [15:0] mem_dataout,
    input  logic        mem_done,
    input  logic        mem_cachehit,
    input  logic        mem_err,
    output logic [15:0] req_cnt,
    output logic [15:0] hit_cnt
);

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 16;
    localparam int unsigned WDW = 8;
    localparam logic [DW-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    state_t         state_q, state_d;
    req_t           req_q;
    logic [DW-1:0]  rdata_q;
    logic [DW-1:0]  req_cnt_q, req_cnt_d;
    logic [DW-1:0]  hit_cnt_q, hit_cnt_d;
    logic [WDW-1:0] wdog_q;
    logic           err_q;
    logic           capture_c;
    logic           wdog_expire_c;
    logic           wdog_last_c;

    // Last permitted BUSY cycle without mem_done
    assign wdog_last_c = (32'(wdog_q) == (WDOG_MAX - 32'd1));

    // Next-state and interface outputs
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        align_err     = 1'b0;
        resp_valid    = 1'b0;
        resp_rdata    = rdata_q;
        mem_addr      = '0;
        mem_datain    = '0;
        mem_rd        = 1'b0;
        mem_wr        = 1'b0;
        capture_c     = 1'b0;
        wdog_expire_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid && !err_q) begin
                    if (req_addr[0]) begin
                        align_err = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        capture_c = 1'b1;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                mem_addr   = req_q.addr;
                mem_datain = req_q.wdata;
                mem_rd     = ~req_q.wr;
                mem_wr     = req_q.wr;
                if (mem_done) begin
                    // A reset in the completion cycle abandons the response
                    resp_valid = ~rst;
                    resp_rdata = mem_dataout;
                    state_d    = IDLE;
                end else begin
                    stall = 1'b1;
                    if (wdog_last_c) begin
                        wdog_expire_c = 1'b1;
                        state_d       = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // After a fatal error the pipeline is frozen on any request
        if (err_q && req_valid) begin
            stall = 1'b1;
        end
    end

    // Saturating statistics counters
    always_comb begin
        req_cnt_d = req_cnt_q;
        hit_cnt_d = hit_cnt_q;
        if (resp_valid && (req_cnt_q != CNT_MAX)) begin
            req_cnt_d = req_cnt_q + 16'd1;
        end
        if (resp_valid && mem_cachehit && (hit_cnt_q != CNT_MAX)) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end
    end

    // State, captured request, load data, watchdog and error registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            req_q     <= '0;
            rdata_q   <= '0;
            req_cnt_q <= '0;
            hit_cnt_q <= '0;
            wdog_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_cnt_q <= req_cnt_d;
            hit_cnt_q <= hit_cnt_d;
            if (capture_c) begin
                req_q.wr    <= req_wr;
                req_q.addr  <= req_addr;
                req_q.wdata <= req_wdata;
            end
            if (resp_valid && !req_q.wr) begin
                rdata_q <= mem_dataout;
            end
            if (capture_c) begin
                wdog_q <= '0;
            end else if ((state_q == BUSY) && !mem_done && !wdog_expire_c) begin
                wdog_q <= wdog_q + 8'd1;
            end
            if (mem_err || wdog_expire_c) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err            = err_q;
    assign req_cnt        = req_cnt_q;
    assign hit_cnt        = hit_cnt_q;
    assign mem_createdump = req_dump;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl: a cycle-by-cycle vector table followed
// by hand-written saturation, watchdog and mem_err sequences.
module tb_mem_req_ctrl;

    localparam int unsigned WDOG = 255;

    typedef struct packed {
        logic        rst;
        logic        valid;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        dump;
        logic [15:0] dout;
        logic        done;
        logic        hit;
        logic        merr;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        resp_valid;
        logic [15:0] resp_rdata;
        logic        align_err;
        logic        err;
        logic [15:0] mem_addr;
        logic [15:0] mem_datain;
        logic        mem_rd;
        logic        mem_wr;
        logic        mem_createdump;
        logic [15:0] req_cnt;
        logic [15:0] hit_cnt;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_wr, req_dump;
    logic [15:0] req_addr, req_wdata;
    logic        stall, resp_valid, align_err, err;
    logic [15:0] resp_rdata, mem_addr, mem_datain;
    logic        mem_rd, mem_wr, mem_createdump;
    logic [15:0] mem_dataout;
    logic        mem_done, mem_cachehit, mem_err;
    logic [15:0] req_cnt, hit_cnt;

    int tests = 0;
    int fails = 0;

    mem_req_ctrl #(.WDOG_MAX(WDOG)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_dump(req_dump),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .align_err(align_err), .err(err),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .mem_createdump(mem_createdump),
        .mem_dataout(mem_dataout), .mem_done(mem_done),
        .mem_cachehit(mem_cachehit), .mem_err(mem_err),
        .req_cnt(req_cnt), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    function automatic in_t mk_in(logic r, logic v, logic w, logic [15:0] a,
                                  logic [15:0] wd, logic dmp, logic [15:0] dout,
                                  logic dn, logic h, logic me);
        in_t x;
        x.rst = r; x.valid = v; x.wr = w; x.addr = a; x.wdata = wd;
        x.dump = dmp; x.dout = dout; x.done = dn; x.hit = h; x.merr = me;
        return x;
    endfunction

    function automatic out_t mk_out(logic st, logic rv, logic [15:0] rd,
                                    logic ae, logic er, logic [15:0] ma,
                                    logic [15:0] md, logic mr, logic mw,
                                    logic cd, logic [15:0] rc, logic [15:0] hc);
        out_t x;
        x.stall = st; x.resp_valid = rv; x.resp_rdata = rd; x.align_err = ae;
        x.err = er; x.mem_addr = ma; x.mem_datain = md; x.mem_rd = mr;
        x.mem_wr = mw; x.mem_createdump = cd; x.req_cnt = rc; x.hit_cnt = hc;
        return x;
    endfunction

    task automatic apply(input in_t x);
        rst = x.rst; req_valid = x.valid; req_wr = x.wr; req_addr = x.addr;
        req_wdata = x.wdata; req_dump = x.dump; mem_dataout = x.dout;
        mem_done = x.done; mem_cachehit = x.hit; mem_err = x.merr;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance to the next cycle's input phase, then settle before checks
    task automatic next_cycle(input in_t x);
        @(negedge clk);
        apply(x);
        #2;
    endtask

    vec_t vecs[$];

    task automatic add(input in_t i, input out_t o);
        vec_t v;
        v.i = i;
        v.o = o;
        vecs.push_back(v);
    endtask

    in_t  idle_in;
    out_t act;

    initial begin
        idle_in = mk_in(0, 0, 0, 16'h0, 16'h0, 0, 16'h0, 0, 0, 0);
        apply(idle_in);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Reset state
        add(idle_in, mk_out(0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,0,16'd0,16'd0));
        // Load hit to 0x0010, done next cycle; req_valid still high during resp
        add(mk_in(0,1,0,16'h0010,16'h0000,0,16'h0000,0,0,0),
            mk_out(1,0,16'h0000,0,0,16'h0000,16'h0000,0,0,0,16'd0,16'd0));
        add(mk_in(0,1,0,16'h0010,16'h0000,0,16'hBEEF,1,1,0),
            mk_out(0,1,16'hBEEF,0,0,16'h0010,16'h0000,1,0,0,16'd0,16'd0));
        add(idle_in, mk_out(0,0,16'hBEEF,0,0,16'h0000,16'h0000,0,0,0,16'd1,16'd1));
        // Misaligned load from 0x0011
        add(mk_in(0,1,0,16'h0011,16'h0000,0,16'h0000,0,0,0),
            mk_out(0,0,16'hBEEF,1,0,16'h0000,16'h0000,0,0,0,16'd1,16'd1));
        add(idle_in, mk_out(0,0,16'hBEEF,0,0,16'h0000,16'h0000,0,0,0,16'd1,16'd1));
        // Store miss 0x1234 -> 0x0020, done on 5th BUSY cycle; request inputs
        // change while BUSY and must not leak to mem_system
        add(mk_in(0,1,1,16'h0020,16'h1234,0,16'h0000,0,0,0),
            mk_out(1,0,16'hBEEF,0,0,16'h0000,16'h0000,0,0,0,16'd1,16'd1));
        for (int k = 0; k < 4; k++)
            add(mk_in(0,1,1,16'hFFF0,16'hAAAA,0,16'h0000,0,0,0),
                mk_out(1,0,16'hBEEF,0,0,16'h0020,16'h1234,0,1,0,16'd1,16'd1));
        add(mk_in(0,1,1,16'hFFF0,16'hAAAA,0,16'h5555,1,0,0),
            mk_out(0,1,16'h5555,0,0,16'h0020,16'h1234,0,1,0,16'd1,16'd1));
        // Store leaves rdata untouched; dump passes straight through
        add(mk_in(0,0,0,16'h0000,16'h0000,1,16'h0000,0,0,0),
            mk_out(0,0,16'hBEEF,0,0,16'h0000,16'h0000,0,0,1,16'd2,16'd1));
        // Reset in the 3rd BUSY cycle of a load miss
        add(mk_in(0,1,0,16'h0040,16'h0000,0,16'h0000,0,0,0),
            mk_out(1,0,16'hBEEF,0,0,16'h0000,16'h0000,0,0,0,16'd2,16'd1));
        for (int k = 0; k < 2; k++)
            add(mk_in(0,1,0,16'h0040,16'h0000,0,16'h0000,0,0,0),
                mk_out(1,0,16'hBEEF,0,0,16'h0040,16'h0000,1,0,0,16'd2,16'd1));
        add(mk_in(1,1,0,16'h0040,16'h0000,0,16'h0000,0,0,0),
            mk_out(1,0,16'hBEEF,0,0,16'h0040,16'h0000,1,0,0,16'd2,16'd1));
        add(idle_in, mk_out(0,0,16'h0000,0,0,16'h0000,16'h0000,0,0,0,16'd0,16'd0));
        // Subsequent load miss completes normally
        add(mk_in(0,1,0,16'h0042,16'h0000,0,16'h0000,0,0,0),
            mk_out(1,0,16'h0000,0,0,16'h0000,16'h0000,0,0,0,16'd0,16'd0));
        add(mk_in(0,1,0,16'h0042,16'h0000,0,16'h0F0F,1,0,0),
            mk_out(0,1,16'h0F0F,0,0,16'h0042,16'h0000,1,0,0,16'd0,16'd0));
        add(idle_in, mk_out(0,0,16'h0F0F,0,0,16'h0000,16'h0000,0,0,0,16'd1,16'd0));

        foreach (vecs[n]) begin
            next_cycle(vecs[n].i);
            act = {stall, resp_valid, resp_rdata, align_err, err, mem_addr,
                   mem_datain, mem_rd, mem_wr, mem_createdump, req_cnt, hit_cnt};
            tests++;
            if (act !== vecs[n].o) begin
                fails++;
                $display("FAIL vec[%0d]: got %h expected %h", n, act, vecs[n].o);
            end
        end

        // Saturation: preload req_cnt to 0xFFFF, then complete a load hit
        @(negedge clk);
        apply(idle_in);
        force dut.req_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.req_cnt_q;
        #2;
        chk("sat_preload", req_cnt, 16'hFFFF);
        next_cycle(mk_in(0,1,0,16'h0050,16'h0000,0,16'h0000,0,0,0));
        chk("sat_req_stall", {15'd0, stall}, 16'd1);
        next_cycle(mk_in(0,0,0,16'h0000,16'h0000,0,16'h1111,1,1,0));
        chk("sat_resp_valid", {15'd0, resp_valid}, 16'd1);
        next_cycle(idle_in);
        chk("sat_req_cnt", req_cnt, 16'hFFFF);
        chk("sat_hit_cnt", hit_cnt, 16'd1);
        chk("sat_rdata", resp_rdata, 16'h1111);

        // Watchdog: load with mem_done never asserted
        next_cycle(mk_in(1,0,0,16'h0000,16'h0000,0,16'h0000,0,0,0));
        next_cycle(idle_in);
        chk("wd_reset_cnt", req_cnt, 16'd0);
        next_cycle(mk_in(0,1,0,16'h0060,16'h0000,0,16'h0000,0,0,0));
        chk("wd_req_stall", {15'd0, stall}, 16'd1);
        begin
            int bad = 0;
            for (int k = 1; k <= int'(WDOG); k++) begin
                next_cycle(mk_in(0,1,0,16'h0060,16'h0000,0,16'h0000,0,0,0));
                if (!(mem_rd === 1'b1 && stall === 1'b1 && err === 1'b0 &&
                      resp_valid === 1'b0 && mem_addr === 16'h0060))
                    bad++;
            end
            chk("wd_busy_cycles_bad", 16'(bad), 16'd0);
        end
        next_cycle(mk_in(0,1,0,16'h0060,16'h0000,0,16'h0000,0,0,0));
        chk("wd_err", {15'd0, err}, 16'd1);
        chk("wd_idle_rd", {15'd0, mem_rd}, 16'd0);
        chk("wd_stall", {15'd0, stall}, 16'd1);
        chk("wd_no_resp", {15'd0, resp_valid}, 16'd0);
        begin
            int issued = 0;
            for (int k = 0; k < 3; k++) begin
                next_cycle(mk_in(0,1,0,16'h0062,16'h0000,0,16'h0000,0,0,0));
                if (mem_rd !== 1'b0 || mem_wr !== 1'b0 || stall !== 1'b1) issued++;
            end
            chk("wd_blocked", 16'(issued), 16'd0);
        end
        chk("wd_req_cnt", req_cnt, 16'd0);

        // mem_err sets a sticky error that only reset clears
        next_cycle(mk_in(1,0,0,16'h0000,16'h0000,0,16'h0000,0,0,0));
        next_cycle(idle_in);
        chk("merr_cleared", {15'd0, err}, 16'd0);
        next_cycle(mk_in(0,0,0,16'h0000,16'h0000,0,16'h0000,0,0,1));
        next_cycle(idle_in);
        chk("merr_sticky", {15'd0, err}, 16'd1);
        next_cycle(mk_in(0,1,1,16'h0070,16'h4321,0,16'h0000,0,0,0));
        chk("merr_stall", {15'd0, stall}, 16'd1);
        next_cycle(mk_in(0,1,1,16'h0070,16'h4321,0,16'h0000,0,0,0));
        chk("merr_no_wr", {15'd0, mem_wr}, 16'd0);
        next_cycle(mk_in(1,0,0,16'h0000,16'h0000,0,16'h0000,0,0,0));
        next_cycle(idle_in);
        chk("merr_rst_clear", {15'd0, err}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
